jk_excite_gen: RTL and testbench
================================

// Module: jk_excite_gen
// PURPOSE
//   Drive side for the JKFF block: converts a stream of target Q bits into the J/K excitation
//   that makes a JKFF (same clk) reproduce that stream one cycle later. Buffers targets in a
//   small FIFO, tracks the expected flop state and checks the flop's q_i fed back
//   (saturating mismatch count). Used as a self-checking JKFF stimulus source.
// PARAMETERS
//   DEPTH    4   target FIFO entries (power of 2, >=2)
//   CNT_W    8   width of mismatch counter
//   DC_MODE  0   don't-care resolution: 0 = X->0 (hold/set/reset), 1 = X->1 (toggle style)
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rst_n        in   1      asynchronous active-low reset
//   tgt_valid_i  in   1      target bit offered
//   tgt_bit_i    in   1      target Q value for the flop
//   tgt_ready_o  out  1      FIFO can accept (= !full, registered-state based)
//   j_o          out  1      J to JKFF (registered)
//   k_o          out  1      K to JKFF (registered)
//   drive_vld_o  out  1      j_o/k_o carry a popped target this cycle
//   q_fb_i       in   1      q_i of the driven JKFF
//   err_clr_i    in   1      synchronous clear of err_cnt_o
//   err_o        out  1      1-cycle pulse: feedback mismatch detected
//   err_cnt_o    out  CNT_W  saturating mismatch count
//   level_o      out  log2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//   Reset: j_o=k_o=0, drive_vld_o=0, err_o=0, err_cnt_o=0, level_o=0, tgt_ready_o=1,
//     model q=0, sync flag=0, checker pipeline cleared. Reset mid-stream discards FIFO.
//   FIFO: push when tgt_valid_i&tgt_ready_o; pop every cycle non-empty. Push+pop same cycle
//     legal (level unchanged); when full, ready=0 even if popping (no pass-through).
//   Edge N (pop, target t, model q): register j_o/k_o per table, drive_vld_o=1, q<=t.
//     q,t: 0,0 -> J=0,K=X | 0,1 -> J=1,K=X | 1,0 -> J=X,K=1 | 1,1 -> J=X,K=0; X per DC_MODE.
//   Sync: flop has no reset, state unknown. First pop after reset (sync=0) emits J=t,K=~t
//     regardless of DC_MODE, then sync<=1.
//   Empty: j_o=k_o=0 (hold), drive_vld_o=0, model q unchanged.
//   Latency: push at edge P -> earliest pop edge P+1 -> JKFF captures at P+2 -> q_fb_i valid
//     until P+3. Checker: at edge N+2 compare q_fb_i against t popped at N (2-stage exp/valid
//     pipeline); mismatch -> err_o=1 for one cycle, err_cnt_o+1 saturating at 2^CNT_W-1.
//   err_clr_i: err_cnt_o<=0; wins over same-cycle increment (that error dropped, err_o still 1).
//   Checker compares only for popped entries; idle cycles never flag errors.
// TESTING
//   T1 DC_MODE=0, push 0,1,1,0 back-to-back after reset -> (J,K)=(0,1),(1,0),(0,0),(0,1);
//     q_fb follows 0,1,1,0; err_cnt_o=0.
//   T2 DC_MODE=1, same stream -> (0,1),(1,1),(1,0),(1,1); q_fb 0,1,1,0; err_cnt_o=0.
//   T3 Fill: hold q_fb source idle? no - stall by pushing 5 bits in one burst with DEPTH=4 while
//     pop runs -> tgt_ready_o drops only when level_o=4; no bit lost or duplicated, order kept.
//   T4 Fault: force q_fb_i=0 with target stream 1,1,1 -> err_o pulses 3 times at N+2 edges,
//     err_cnt_o=3; err_clr_i coincident with 3rd error -> err_cnt_o=0.
//   T5 Saturation: CNT_W=2, 5 forced mismatches -> err_cnt_o sticks at 3.
//   T6 rst_n low mid-burst (level_o=3) -> outputs to reset values immediately; after release
//     first pop uses J=t,K=~t; stale checker entries do not raise err_o.

Source files
------------

// File: rtl/jk_excite_gen.sv
// jk_excite_gen: turns a stream of target Q bits into J/K drive for a JKFF and checks its q feedback.
module jk_excite_gen #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int DC_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tgt_valid_i,
  input  logic                       tgt_bit_i,
  output logic                       tgt_ready_o,
  output logic                       j_o,
  output logic                       k_o,
  output logic                       drive_vld_o,
  input  logic                       q_fb_i,
  input  logic                       err_clr_i,
  output logic                       err_o,
  output logic [CNT_W-1:0]           err_cnt_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic DC = (DC_MODE != 0);
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] level_q, level_d;
  logic j_q, j_d, k_q, k_d, vld_q, vld_d, mq_q, mq_d, sync_q, sync_d;
  logic e1v_q, e1v_d, e1t_q, e1t_d, e2v_q, e2v_d, e2t_q, e2t_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic full, push, pop, t, mism;
  always_comb begin
    full    = (level_q == (AW+1)'(DEPTH));
    push    = tgt_valid_i & ~full;
    pop     = (level_q != '0);
    t       = mem_q[rp_q];
    mem_d   = mem_q;
    if (push) mem_d[wp_q] = tgt_bit_i;
    wp_d    = wp_q + AW'(push);
    rp_d    = rp_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    // Until the flop state is known, force it explicitly with J=t,K=~t.
    j_d     = !pop ? 1'b0 : !sync_q ? t  : mq_q ? DC : t;
    k_d     = !pop ? 1'b0 : !sync_q ? ~t : mq_q ? ~t : DC;
    vld_d   = pop;
    mq_d    = pop ? t : mq_q;
    sync_d  = sync_q | pop;
    e1v_d   = pop;
    e1t_d   = t;
    e2v_d   = e1v_q;
    e2t_d   = e1t_q;
    mism    = e2v_q & (q_fb_i != e2t_q);
    err_d   = mism;
    cnt_d   = err_clr_i ? '0 : (mism && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      vld_q   <= 1'b0;
      mq_q    <= 1'b0;
      sync_q  <= 1'b0;
      e1v_q   <= 1'b0;
      e1t_q   <= 1'b0;
      e2v_q   <= 1'b0;
      e2t_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      j_q     <= j_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      mq_q    <= mq_d;
      sync_q  <= sync_d;
      e1v_q   <= e1v_d;
      e1t_q   <= e1t_d;
      e2v_q   <= e2v_d;
      e2t_q   <= e2t_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign tgt_ready_o = ~full;
  assign j_o         = j_q;
  assign k_o         = k_q;
  assign drive_vld_o = vld_q;
  assign err_o       = err_q;
  assign err_cnt_o   = cnt_q;
  assign level_o     = level_q;
endmodule

// File: tb/tb_jk_excite_gen.sv
// tb_jk_excite_gen: two DUTs (DC_MODE 0/1, CNT_W 8/2) share stimulus and are checked against a queue model.
module tb_jk_excite_gen;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tgt_valid = 1'b0, tgt_bit = 1'b0, err_clr = 1'b0, fault = 1'b0;
  logic rdy0, j0, k0, v0, e0, qfb0, rdy1, j1, k1, v1, e1, qfb1;
  logic [7:0] c0;
  logic [1:0] c1;
  logic [2:0] l0, l1;
  logic jq0 = 1'b1, jq1 = 1'b0;
  always #5 clk = ~clk;
  jk_excite_gen #(.DEPTH(DEPTH), .CNT_W(8), .DC_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .tgt_valid_i(tgt_valid), .tgt_bit_i(tgt_bit), .tgt_ready_o(rdy0),
    .j_o(j0), .k_o(k0), .drive_vld_o(v0), .q_fb_i(qfb0), .err_clr_i(err_clr), .err_o(e0),
    .err_cnt_o(c0), .level_o(l0));
  jk_excite_gen #(.DEPTH(DEPTH), .CNT_W(2), .DC_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tgt_valid_i(tgt_valid), .tgt_bit_i(tgt_bit), .tgt_ready_o(rdy1),
    .j_o(j1), .k_o(k1), .drive_vld_o(v1), .q_fb_i(qfb1), .err_clr_i(err_clr), .err_o(e1),
    .err_cnt_o(c1), .level_o(l1));
  // Behavioural JKFFs (no reset) driven by each DUT; fault pulls the feedback low.
  always @(posedge clk) begin
    jq0 <= (j0 & k0) ? ~jq0 : j0 ? 1'b1 : k0 ? 1'b0 : jq0;
    jq1 <= (j1 & k1) ? ~jq1 : j1 ? 1'b1 : k1 ? 1'b0 : jq1;
  end
  assign qfb0 = fault ? 1'b0 : jq0;
  assign qfb1 = fault ? 1'b0 : jq1;
  typedef struct { int due; bit t; } pend_t;
  bit    tq[$];
  pend_t pend[$];
  bit    mq, msync, xj0, xk0, xj1, xk1, xv, xe;
  int    xc0, xc1, cyc, npass, ntot;
  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    tq.delete();
    pend.delete();
    mq = 0; msync = 0; xj0 = 0; xk0 = 0; xj1 = 0; xk1 = 0; xv = 0; xe = 0; xc0 = 0; xc1 = 0;
  endtask
  task automatic model_step(input bit v, input bit b, input bit c, input bit f);
    bit push, pop, t, mism;
    pend_t p;
    push = v && (tq.size() < DEPTH);
    pop  = tq.size() > 0;
    mism = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      mism = f && p.t;
    end
    xe  = mism;
    xc0 = c ? 0 : (mism && xc0 < 255) ? xc0 + 1 : xc0;
    xc1 = c ? 0 : (mism && xc1 < 3) ? xc1 + 1 : xc1;
    xv  = pop;
    if (pop) begin
      t = tq.pop_front();
      if (!msync) begin
        xj0 = t; xk0 = !t; xj1 = t; xk1 = !t; msync = 1;
      end else if (!mq) begin
        xj0 = t; xk0 = 0; xj1 = t; xk1 = 1;
      end else begin
        xj0 = 0; xk0 = !t; xj1 = 1; xk1 = !t;
      end
      mq = t;
      pend.push_back('{cyc + 2, t});
    end else begin
      xj0 = 0; xk0 = 0; xj1 = 0; xk1 = 0;
    end
    if (push) tq.push_back(b);
    cyc++;
  endtask
  task automatic check_all();
    chk("j0", int'(j0), int'(xj0));
    chk("k0", int'(k0), int'(xk0));
    chk("j1", int'(j1), int'(xj1));
    chk("k1", int'(k1), int'(xk1));
    chk("vld0", int'(v0), int'(xv));
    chk("vld1", int'(v1), int'(xv));
    chk("err0", int'(e0), int'(xe));
    chk("err1", int'(e1), int'(xe));
    chk("cnt0", int'(c0), xc0);
    chk("cnt1", int'(c1), xc1);
    chk("level0", int'(l0), tq.size());
    chk("level1", int'(l1), tq.size());
    chk("ready0", int'(rdy0), int'(tq.size() < DEPTH));
    chk("ready1", int'(rdy1), int'(tq.size() < DEPTH));
  endtask
  task automatic step(input bit v, input bit b, input bit c, input bit f);
    tgt_valid = v; tgt_bit = b; err_clr = c; fault = f;
    @(posedge clk);
    model_step(v, b, c, f);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    npass = 0; ntot = 0; cyc = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    // Canonical stream 0,1,1,0 back to back, then drain.
    step(1, 0, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Continuous burst with pop running.
    for (int i = 0; i < 6; i++) step(1, 1'($urandom_range(0, 1)), 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Forced-low feedback on 1,1,1 with clear coincident with the third error.
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 1, 1); step(0, 0, 0, 1);
    // Saturation: five forced mismatches.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    // Reset with checks in flight; stale entries must not flag.
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 0, 0, 1);
    do_reset();
    repeat (3) step(0, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0));
    repeat (4) step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
